// File: rtl/param_fifo.sv
// param_fifo: single-clock synchronous FIFO with registered read data,
// occupancy count, threshold flags and overflow/underflow reporting.
// Optional build macro: PARAM_FIFO_STICKY_ERR_EN makes overflow/underflow
// sticky until reset; without it they are one-cycle pulses.
//
// Request semantics: push and pop are requests with no ready signal.
// A pop is accepted when the FIFO is not empty. A push is accepted when
// the FIFO is not full, or when a pop is accepted in the same cycle.
// A request that is not accepted has no effect on storage, pointers or
// data_out, and is reported one cycle later on overflow/underflow.
// Read data appears on data_out with en=1 one cycle after an accepted pop.
module param_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     push,
  input  logic                     pop,
  output logic [DATA_W-1:0]        data_out,
  output logic                     en,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_TH_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_TH_C = CW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_next;
  logic              pop_ok;
  logic              push_ok;
  logic              push_rej;
  logic              pop_rej;

  // Acceptance decisions and next occupancy.
  always_comb begin
    pop_ok     = 1'b0;
    push_ok    = 1'b0;
    push_rej   = 1'b0;
    pop_rej    = 1'b0;
    count_next = count;
    pop_ok     = pop && !fifo_empty;
    push_ok    = push && (!fifo_full || pop_ok);
    push_rej   = push && !push_ok;
    pop_rej    = pop && !pop_ok;
    if (push_ok && !pop_ok) begin
      count_next = count + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count - CW'(1);
    end
  end

  // Storage write; contents are not reset. When full with push+pop the
  // write pointer equals the read pointer, so the new word lands in the
  // slot being read this cycle (the read below still sees the old word).
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, count, registered flags and registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      en           <= 1'b0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b0;
    end else begin
      count        <= count_next;
      fifo_full    <= (count_next == DEPTH_C);
      fifo_empty   <= (count_next == '0);
      almost_full  <= (count_next >= AFULL_TH_C);
      almost_empty <= (count_next <= AEMPTY_TH_C);
      en           <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
    end
  end

  // Rejected-request reporting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
`ifdef PARAM_FIFO_STICKY_ERR_EN
      overflow  <= overflow  | push_rej;
      underflow <= underflow | pop_rej;
`else
      overflow  <= push_rej;
      underflow <= pop_rej;
`endif
    end
  end

endmodule
